// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the fetch requester, data requester and Memory-side
//             signals shared by mem_port_arbiter.
//  Modports : slave  - the arbiter (sees requests and mem_rdata, drives
//                      grants, responses and Memory controls)
//             master - the requesters plus Memory (the opposite direction)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares a single-port Memory between instruction fetch and the
//             data path. One access at a time: IDLE -> ISSUE -> WAIT -> RESP,
//             round-robin between the two requesters on a tie.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low reset
//             bus    - mem_port_arbiter_if.slave (requests, grants,
//                      responses and Memory controls; all outputs registered)
//  Params   : ADDR_W, DATA_W - bus widths (must match the interface)
//             MEM_LAT        - Memory read latency in clock edges, 1..4
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    // Elaboration-time parameter sanity checks
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_badLat
        $error("mem_port_arbiter: MEM_LAT=%0d outside legal range 1..4", MEM_LAT);
    end
    if ($bits(bus.mem_addr) != ADDR_W || $bits(bus.mem_wdata) != DATA_W) begin : g_badWidth
        $error("mem_port_arbiter: interface widths do not match ADDR_W/DATA_W");
    end

    localparam logic       c_FETCH  = 1'b0;
    localparam logic       c_DATA   = 1'b1;
    localparam logic [1:0] c_LAT_M1 = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_owner;      // requester that owns the current access
    logic       r_lastGrant;  // requester granted most recently (tie-break)
    logic       r_ownerWe;    // current access is a write
    logic [1:0] r_waitCnt;

    logic w_anyReq;
    logic w_pickData;

    // On a tie the requester not granted last wins.
    always_comb begin
        w_anyReq = bus.if_req | bus.d_req;
        if (bus.if_req && bus.d_req) begin
            w_pickData = (r_lastGrant == c_FETCH);
        end else begin
            w_pickData = bus.d_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_owner       <= c_FETCH;
            r_lastGrant   <= c_FETCH;
            r_ownerWe     <= 1'b0;
            r_waitCnt     <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
        end else begin
            // Grants, responses and Memory strobes are single-cycle pulses.
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;

            case (r_state)
                // RESP exits through the same arbitration as IDLE, so a
                // waiting request is granted without an idle bubble.
                S_IDLE, S_RESP: begin
                    if (w_anyReq) begin
                        r_state     <= S_ISSUE;
                        r_owner     <= w_pickData;
                        r_lastGrant <= w_pickData;
                        if (w_pickData) begin
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_read  <= ~bus.d_we;
                            bus.mem_write <= bus.d_we;
                            bus.d_gnt     <= 1'b1;
                            r_ownerWe     <= bus.d_we;
                        end else begin
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_read  <= 1'b1;
                            bus.if_gnt    <= 1'b1;
                            r_ownerWe     <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                // Memory samples the command at the ISSUE exit edge; its
                // DataOut is valid MEM_LAT edges later, i.e. after the
                // counter has run from MEM_LAT-1 down to 0 in WAIT.
                S_ISSUE: begin
                    r_waitCnt <= c_LAT_M1;
                    r_state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_waitCnt == 2'd0) begin
                        r_state <= S_RESP;
                        if (r_owner == c_DATA) begin
                            bus.d_rvalid <= 1'b1;
                            bus.d_rdata  <= r_ownerWe ? '0 : bus.mem_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt - 2'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter. Instance A uses
//             MEM_LAT=1, instance B MEM_LAT=3; each has a small Memory model
//             whose DataOut is valid for exactly one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [63:0] c_JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if busA ();
    mem_port_arbiter_if busB ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dutA (
        .clk(clk), .reset(reset), .bus(busA)
    );
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dutB (
        .clk(clk), .reset(reset), .bus(busB)
    );

    // ---------------- Memory models ----------------
    logic [63:0] memA [256];
    logic [63:0] memB [256];
    bit          paV;
    logic [63:0] paD;
    bit          pbV [3];
    logic [63:0] pbD [3];

    always @(posedge clk) begin
        if (busA.mem_write) memA[busA.mem_addr[7:0]] <= busA.mem_wdata;
        paV <= busA.mem_read;
        paD <= memA[busA.mem_addr[7:0]];
        if (busB.mem_write) memB[busB.mem_addr[7:0]] <= busB.mem_wdata;
        pbV[0] <= busB.mem_read;
        pbD[0] <= memB[busB.mem_addr[7:0]];
        pbV[1] <= pbV[0];
        pbD[1] <= pbD[0];
        pbV[2] <= pbV[1];
        pbD[2] <= pbD[1];
    end
    assign busA.mem_rdata = paV    ? paD    : c_JUNK;
    assign busB.mem_rdata = pbV[2] ? pbD[2] : c_JUNK;

    // ---------------- Scoreboard ----------------
    typedef struct {
        int          port;   // 0 = fetch, 1 = data
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        int          cyc;    // -1 = cycle not checked
    } gexp_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        int          cyc;
    } rexp_t;

    gexp_t gq0[$], gq1[$];
    rexp_t rq0[$], rq1[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gntSeen[2];
    int rvSeen[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int inst, input logic ig, dg, iv, dv,
                       input logic [63:0] ird, drd, ma, mwd, input logic mr, mw);
        gexp_t g;
        rexp_t r;
        int p;
        logic [63:0] rd;
        bit ok;
        if (ig || dg) begin
            gntSeen[inst]++;
            checks++;
            if ((inst == 0 && gq0.size() == 0) || (inst == 1 && gq1.size() == 0)) begin
                errors++;
                $display("FAIL gnt_unexpected inst%0d if_gnt %b d_gnt %b required no grant", inst, ig, dg);
            end else begin
                if (inst == 0) g = gq0.pop_front(); else g = gq1.pop_front();
                p  = dg ? 1 : 0;
                ok = !(ig && dg) && (p == g.port) && (ma == g.addr) && (mr == !g.we) &&
                     (mw == g.we) && (mwd == g.wdata) && (g.cyc < 0 || g.cyc == cyc);
                if (!ok) begin
                    errors++;
                    $display("FAIL gnt inst%0d actual port %0d(if%b d%b) addr %h rd %b wr %b wdata %h cyc %0d required port %0d addr %h we %b wdata %h cyc %0d",
                             inst, p, ig, dg, ma, mr, mw, mwd, cyc, g.port, g.addr, g.we, g.wdata, g.cyc);
                end
            end
        end
        if (iv || dv) begin
            rvSeen[inst]++;
            checks++;
            if ((inst == 0 && rq0.size() == 0) || (inst == 1 && rq1.size() == 0)) begin
                errors++;
                $display("FAIL rvalid_unexpected inst%0d if_rvalid %b d_rvalid %b required no response", inst, iv, dv);
            end else begin
                if (inst == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                p  = dv ? 1 : 0;
                rd = dv ? drd : ird;
                ok = !(iv && dv) && (p == r.port) && (rd == r.data) && (r.cyc < 0 || r.cyc == cyc);
                if (!ok) begin
                    errors++;
                    $display("FAIL rvalid inst%0d actual port %0d(if%b d%b) data %h cyc %0d required port %0d data %h cyc %0d",
                             inst, p, iv, dv, rd, cyc, r.port, r.data, r.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, busA.if_gnt, busA.d_gnt, busA.if_rvalid, busA.d_rvalid, busA.if_rdata,
            busA.d_rdata, busA.mem_addr, busA.mem_wdata, busA.mem_read, busA.mem_write);
        mon(1, busB.if_gnt, busB.d_gnt, busB.if_rvalid, busB.d_rvalid, busB.if_rdata,
            busB.d_rdata, busB.mem_addr, busB.mem_wdata, busB.mem_read, busB.mem_write);
    end

    // ---------------- Stimulus helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic setReq(input int inst, input int port, input logic v, we,
                          input logic [63:0] addr, wd);
        if (inst == 0) begin
            if (port == 1) begin
                busA.d_req = v; busA.d_we = we; busA.d_addr = addr; busA.d_wdata = wd;
            end else begin
                busA.if_req = v; busA.if_addr = addr;
            end
        end else begin
            if (port == 1) begin
                busB.d_req = v; busB.d_we = we; busB.d_addr = addr; busB.d_wdata = wd;
            end else begin
                busB.if_req = v; busB.if_addr = addr;
            end
        end
    endtask

    // Returns at negedge+1 once the monitor count reaches target.
    task automatic waitFor(input string what, input int inst, input bit isGnt, input int target);
        for (int i = 0; i < 40; i++) begin
            if ((isGnt ? gntSeen[inst] : rvSeen[inst]) >= target) return;
            @(negedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s inst%0d actual count %0d required %0d", what, inst,
                 isGnt ? gntSeen[inst] : rvSeen[inst], target);
    endtask

    function automatic gexp_t mkG(int port, logic [63:0] addr, logic we, logic [63:0] wd, int c);
        gexp_t g;
        g.port = port; g.addr = addr; g.we = we; g.wdata = (port == 1) ? wd : 64'd0; g.cyc = c;
        return g;
    endfunction

    function automatic rexp_t mkR(int port, logic [63:0] data, int c);
        rexp_t r;
        r.port = port; r.data = data; r.cyc = c;
        return r;
    endfunction

    task automatic pushExp(input int inst, input gexp_t g, input bit hasR, input rexp_t r);
        if (inst == 0) begin
            gq0.push_back(g); if (hasR) rq0.push_back(r);
        end else begin
            gq1.push_back(g); if (hasR) rq1.push_back(r);
        end
    endtask

    // One access issued from an idle arbiter; cycles are fully timed.
    task automatic access(input int inst, input int port, input logic we,
                          input logic [63:0] addr, wd, expRd, input bit expectRv);
        int lat, e0, g0, r0;
        lat = (inst == 0) ? 1 : 3;
        @(posedge clk); #1;
        e0 = cyc + 1;
        pushExp(inst, mkG(port, addr, we, wd, e0), expectRv, mkR(port, expRd, e0 + 1 + lat));
        g0 = gntSeen[inst];
        r0 = rvSeen[inst];
        setReq(inst, port, 1'b1, we, addr, wd);
        waitFor("gnt", inst, 1'b1, g0 + 1);
        setReq(inst, port, 1'b0, 1'b0, 64'd0, 64'd0);
        if (expectRv) waitFor("rvalid", inst, 1'b0, r0 + 1);
    endtask

    // ---------------- Directed tests ----------------
    initial begin
        int e0, g0, r0;
        for (int i = 0; i < 256; i++) begin
            memA[i] = 64'h1000 + 64'(i);
            memB[i] = 64'h2000 + 64'(i);
        end
        memA[8] = 64'h55;
        memB[8] = 64'h77;
        setReq(0, 0, 1'b0, 1'b0, 64'd0, 64'd0);
        setReq(0, 1, 1'b0, 1'b0, 64'd0, 64'd0);
        setReq(1, 0, 1'b0, 1'b0, 64'd0, 64'd0);
        setReq(1, 1, 1'b0, 1'b0, 64'd0, 64'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A_gnt",    {62'd0, busA.if_gnt, busA.d_gnt}, 64'd0);
        chk("rst_A_rvalid", {62'd0, busA.if_rvalid, busA.d_rvalid}, 64'd0);
        chk("rst_A_mem_rw", {62'd0, busA.mem_read, busA.mem_write}, 64'd0);
        chk("rst_A_addr",   busA.mem_addr, 64'd0);
        chk("rst_A_wdata",  busA.mem_wdata, 64'd0);
        chk("rst_A_ifrd",   busA.if_rdata, 64'd0);
        chk("rst_A_drd",    busA.d_rdata, 64'd0);
        chk("rst_B_ctl",    {58'd0, busB.if_gnt, busB.d_gnt, busB.if_rvalid, busB.d_rvalid,
                             busB.mem_read, busB.mem_write}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Simultaneous requests from reset: D, F, D, F, one access per 3 cycles
        @(posedge clk); #1;
        e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (k % 2 == 0) ? 1 : 0;
            pushExp(0, mkG(p, (p == 1) ? 64'd24 : 64'd8, 1'b0, 64'd0, e0 + 3 * k), 1'b1,
                    mkR(p, (p == 1) ? 64'h1018 : 64'h55, e0 + 2 + 3 * k));
        end
        g0 = gntSeen[0];
        r0 = rvSeen[0];
        setReq(0, 1, 1'b1, 1'b0, 64'd24, 64'd0);
        setReq(0, 0, 1'b1, 1'b0, 64'd8, 64'd0);
        waitFor("rr_gnt", 0, 1'b1, g0 + 4);
        setReq(0, 1, 1'b0, 1'b0, 64'd0, 64'd0);
        setReq(0, 0, 1'b0, 1'b0, 64'd0, 64'd0);
        waitFor("rr_rvalid", 0, 1'b0, r0 + 4);

        // Fetch read, MEM_LAT=1
        access(0, 0, 1'b0, 64'd8, 64'd0, 64'h55, 1'b1);
        // Data write then read back
        access(0, 1, 1'b1, 64'd16, 64'hABCD, 64'd0, 1'b1);
        access(0, 1, 1'b0, 64'd16, 64'd0, 64'hABCD, 1'b1);

        // MEM_LAT=3 fetch: rvalid four edges after the grant edge
        access(1, 0, 1'b0, 64'd8, 64'd0, 64'h77, 1'b1);

        // Data request arriving while a fetch is in WAIT
        @(posedge clk); #1;
        e0 = cyc + 1;
        pushExp(1, mkG(0, 64'd40, 1'b0, 64'd0, e0), 1'b1, mkR(0, 64'h2028, e0 + 4));
        pushExp(1, mkG(1, 64'd56, 1'b0, 64'd0, e0 + 5), 1'b1, mkR(1, 64'h2038, e0 + 9));
        g0 = gntSeen[1];
        r0 = rvSeen[1];
        setReq(1, 0, 1'b1, 1'b0, 64'd40, 64'd0);
        waitFor("wait_f_gnt", 1, 1'b1, g0 + 1);
        setReq(1, 0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        setReq(1, 1, 1'b1, 1'b0, 64'd56, 64'd0);
        waitFor("wait_d_gnt", 1, 1'b1, g0 + 2);
        setReq(1, 1, 1'b0, 1'b0, 64'd0, 64'd0);
        waitFor("wait_rvalid", 1, 1'b0, r0 + 2);

        // Reset during WAIT of a data read: request is abandoned
        access(1, 1, 1'b0, 64'd48, 64'd0, 64'd0, 1'b0);
        r0 = rvSeen[1];
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("midrst_mem_read", {63'd0, busB.mem_read}, 64'd0);
        chk("midrst_gnt",      {62'd0, busB.if_gnt, busB.d_gnt}, 64'd0);
        chk("midrst_rvalid",   {62'd0, busB.if_rvalid, busB.d_rvalid}, 64'd0);
        chk("midrst_addr",     busB.mem_addr, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("lost_no_rvalid", 64'(rvSeen[1]), 64'(r0));
        access(1, 1, 1'b0, 64'd48, 64'd0, 64'h2030, 1'b1);

        repeat (6) @(posedge clk);
        #1;
        chk("left_gnt_A", 64'(gq0.size()), 64'd0);
        chk("left_rv_A",  64'(rq0.size()), 64'd0);
        chk("left_gnt_B", 64'(gq1.size()), 64'd0);
        chk("left_rv_B",  64'(rq1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual no finish required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
